// File: rtl/regs_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regs_wb_arbiter
//  Purpose  : Two-port register-file writeback arbiter with a pending-write
//             scoreboard for multi-cycle operations.
//             - p0 (pipeline) has priority. p1 (multi-cycle unit) is forced
//               through after MAX_WAIT consecutive denied cycles.
//             - The granted transfer is registered onto w_regs_* one cycle
//               after the handshake. Writes to x0 are accepted but produce
//               w_regs_en = 0.
//             - The scoreboard marks registers with an outstanding
//               multi-cycle write. Decode queries it through q_addr1/q_addr2.
//  Ports    : clk, rst (synchronous, active-low)
//             p0_valid/p0_ready/p0_addr/p0_data   pipeline writeback
//             p1_valid/p1_ready/p1_addr/p1_data   multi-cycle writeback
//             sb_set_en/sb_set_addr               mark register pending
//             q_addr1/q_addr2 -> q_busy1/q_busy2  pending-write queries
//             w_regs_en/w_regs_addr/w_regs_data   register-file write port
//  Revision : 1.0 - initial release
// ============================================================================
module regs_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p0_valid,
  output logic            p0_ready,
  input  logic [4:0]      p0_addr,
  input  logic [XLEN-1:0] p0_data,
  input  logic            p1_valid,
  output logic            p1_ready,
  input  logic [4:0]      p1_addr,
  input  logic [XLEN-1:0] p1_data,
  input  logic            sb_set_en,
  input  logic [4:0]      sb_set_addr,
  input  logic [4:0]      q_addr1,
  input  logic [4:0]      q_addr2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic            w_regs_en,
  output logic [4:0]      w_regs_addr,
  output logic [XLEN-1:0] w_regs_data
);

  // Counter must hold the value MAX_WAIT itself; keep at least one bit.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      sb_q, sb_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;

  logic             force_p1;
  logic             xfer0;
  logic             xfer1;

  always_comb begin
    force_p1   = (wait_cnt_q >= C_MAX_WAIT);

    // Readies are qualified by their own valid and held low during reset.
    p0_ready   = rst && p0_valid && (!p1_valid || !force_p1);
    p1_ready   = rst && p1_valid && (!p0_valid ||  force_p1);

    xfer0      = p0_valid && p0_ready;
    xfer1      = p1_valid && p1_ready;

    // Counts consecutive cycles p1 is left waiting; saturates at MAX_WAIT.
    wait_cnt_d = wait_cnt_q;
    if (!p1_valid || xfer1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < C_MAX_WAIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    // Registered write port: addr/data hold when nothing transfers.
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer0) begin
      wen_d   = (p0_addr != 5'd0);
      waddr_d = p0_addr;
      wdata_d = p0_data;
    end else if (xfer1) begin
      wen_d   = (p1_addr != 5'd0);
      waddr_d = p1_addr;
      wdata_d = p1_data;
    end

    // Clear is applied before set so a same-cycle re-issue keeps the bit set.
    sb_d = sb_q;
    if (xfer1) begin
      sb_d[p1_addr] = 1'b0;
    end
    if (sb_set_en && (sb_set_addr != 5'd0)) begin
      sb_d[sb_set_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      sb_q       <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      sb_q       <= sb_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign q_busy1     = sb_q[q_addr1];
  assign q_busy2     = sb_q[q_addr2];
  assign w_regs_en   = wen_q;
  assign w_regs_addr = waddr_q;
  assign w_regs_data = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regs_wb_arbiter
//  Purpose  : Self-checking bench for regs_wb_arbiter. A driver applies one
//             input set per cycle, pushes the expected outputs from a
//             behavioural model into a queue, and a monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regs_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;

  logic            clk;
  logic            rst;
  logic            p0_valid, p1_valid;
  logic            p0_ready, p1_ready;
  logic [4:0]      p0_addr, p1_addr;
  logic [XLEN-1:0] p0_data, p1_data;
  logic            sb_set_en;
  logic [4:0]      sb_set_addr, q_addr1, q_addr2;
  logic            q_busy1, q_busy2;
  logic            w_regs_en;
  logic [4:0]      w_regs_addr;
  logic [XLEN-1:0] w_regs_data;

  regs_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_data(p1_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .w_regs_en(w_regs_en), .w_regs_addr(w_regs_addr), .w_regs_data(w_regs_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          r0;
    bit          r1;
    bit          b1;
    bit          b2;
    bit          wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   fails   = 0;

  // Reference model state (after the most recent clock edge).
  int          denied;
  bit          pend[32];
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, push the expectation for this cycle, advance model.
  task automatic drive(input bit r, input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit se, input logic [4:0] sa,
                       input logic [4:0] qa1, input logic [4:0] qa2);
    exp_t e;
    bit   g0, g1;
    @(negedge clk);
    rst = r; p0_valid = v0; p0_addr = a0; p0_data = d0;
    p1_valid = v1; p1_addr = a1; p1_data = d1;
    sb_set_en = se; sb_set_addr = sa; q_addr1 = qa1; q_addr2 = qa2;

    if (!r)            begin g0 = 0;  g1 = 0;  end
    else if (v0 && v1) begin g1 = (denied >= MAX_WAIT); g0 = !g1; end
    else               begin g0 = v0; g1 = v1; end

    e.r0 = g0; e.r1 = g1;
    e.b1 = pend[qa1]; e.b2 = pend[qa2];
    e.wen = m_wen; e.waddr = m_waddr; e.wdata = m_wdata;
    exp_q.push_back(e);

    if (!r) begin
      denied = 0;
      foreach (pend[i]) pend[i] = 0;
      m_wen = 0; m_waddr = '0; m_wdata = '0;
    end else begin
      if (g1 || !v1)             denied = 0;
      else if (denied < MAX_WAIT) denied++;
      if (g1) pend[a1] = 0;
      if (se && sa != 0) pend[sa] = 1;
      if (g0)      begin m_wen = (a0 != 0); m_waddr = a0; m_wdata = d0; end
      else if (g1) begin m_wen = (a1 != 0); m_waddr = a1; m_wdata = d1; end
      else         m_wen = 0;
    end
  endtask

  task automatic idle(input logic [4:0] qa1, input logic [4:0] qa2);
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, qa1, qa2);
  endtask

  // Monitor: compares DUT outputs against the queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("p0_ready",    {31'd0, p0_ready},  {31'd0, e.r0});
        chk("p1_ready",    {31'd0, p1_ready},  {31'd0, e.r1});
        chk("q_busy1",     {31'd0, q_busy1},   {31'd0, e.b1});
        chk("q_busy2",     {31'd0, q_busy2},   {31'd0, e.b2});
        chk("w_regs_en",   {31'd0, w_regs_en}, {31'd0, e.wen});
        chk("w_regs_addr", {27'd0, w_regs_addr}, {27'd0, e.waddr});
        chk("w_regs_data", w_regs_data,        e.wdata);
      end
    end
  end

  initial begin
    rst = 0; p0_valid = 0; p1_valid = 0; p0_addr = '0; p1_addr = '0;
    p0_data = '0; p1_data = '0; sb_set_en = 0; sb_set_addr = '0;
    q_addr1 = '0; q_addr2 = '0;
    repeat (2) @(posedge clk);
    denied = 0; m_wen = 0; m_waddr = '0; m_wdata = '0;
    foreach (pend[i]) pend[i] = 0;

    // Readies stay low while reset is held, even with both valids high.
    drive(0, 1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 0, 5'd0, 5'd0, 5'd0);

    // Lone p0 write.
    drive(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Continuous contention: p1 forced through after MAX_WAIT denials.
    for (int i = 0; i < 12; i++)
      drive(1, 1, 5'(i + 1), $urandom, 1, 5'd3, 32'hA000 + i, 0, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Scoreboard set then clear by p1 transfer.
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7, 5'd7, 5'd8);
    idle(5'd7, 5'd8);
    drive(1, 0, 5'd0, 32'd0, 1, 5'd7, 32'h77, 0, 5'd0, 5'd7, 5'd8);
    idle(5'd7, 5'd8);

    // Same-cycle set and clear of register 9: set wins.
    drive(1, 0, 5'd0, 32'd0, 1, 5'd9, 32'h99, 1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    idle(5'd9, 5'd0);

    // x0 write is consumed but dropped; x0 never becomes pending.
    drive(1, 0, 5'd0, 32'd0, 1, 5'd0, 32'h1234, 1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Reset in the middle of activity.
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd3, 5'd3, 5'd12);
    drive(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd12, 5'd3, 5'd12);
    drive(1, 1, 5'd4, 32'hCAFE, 1, 5'd6, 32'hF00D, 0, 5'd0, 5'd3, 5'd12);
    drive(0, 1, 5'd4, 32'hCAFE, 1, 5'd6, 32'hF00D, 0, 5'd0, 5'd3, 5'd12);
    idle(5'd3, 5'd12);
    // Contention right after reset confirms the wait count restarted at 0.
    for (int i = 0; i < 6; i++)
      drive(1, 1, 5'd10, 32'hB0 + i, 1, 5'd11, 32'hC0 + i, 0, 5'd0, 5'd3, 5'd12);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) > 2),
            ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    idle(5'd0, 5'd0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regs_wb_arbiter.md
REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of register writes.
REQ-002 SHALL have parameter MAX_WAIT, default 4, consecutive cycles port 1 may be denied before it is forced through.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port p0_valid, input, 1, pipeline writeback request.
REQ-006 SHALL have port p0_ready, output, 1, pipeline request accepted this cycle.
REQ-007 SHALL have port p0_addr, input, 5, pipeline destination register.
REQ-008 SHALL have port p0_data, input, XLEN, pipeline write data.
REQ-009 SHALL have port p1_valid, input, 1, multi-cycle unit writeback request.
REQ-010 SHALL have port p1_ready, output, 1, multi-cycle request accepted this cycle.
REQ-011 SHALL have port p1_addr, input, 5, multi-cycle destination register.
REQ-012 SHALL have port p1_data, input, XLEN, multi-cycle write data.
REQ-013 SHALL have port sb_set_en, input, 1, multi-cycle op issued; mark sb_set_addr pending.
REQ-014 SHALL have port sb_set_addr, input, 5, destination of issued multi-cycle op.
REQ-015 SHALL have ports q_addr1 and q_addr2, input, 5 each, decode-stage source registers to check.
REQ-016 SHALL have ports q_busy1 and q_busy2, output, 1 each, queried register has a pending multi-cycle write.
REQ-017 SHALL have port w_regs_en, output, 1, register-file write enable.
REQ-018 SHALL have port w_regs_addr, output, 5, register-file write address.
REQ-019 SHALL have port w_regs_data, output, XLEN, register-file write data.

Function
REQ-020 SHALL accept at most one request per cycle; a transfer occurs on valid && ready.
REQ-021 SHALL compute p0_ready and p1_ready combinationally from the valids and the wait counter; ready SHALL never be asserted to a port whose valid is low.
REQ-022 SHALL grant p0 when only p0 is valid, and p1 when only p1 is valid.
REQ-023 SHALL grant p0 when both are valid and wait_cnt < MAX_WAIT, else grant p1.
REQ-024 SHALL increment the saturating wait_cnt each cycle p1_valid is high and p1 is not granted; it SHALL clear to 0 on any p1 grant or whenever p1_valid is low.
REQ-025 SHALL register the granted transfer: w_regs_en/addr/data appear exactly one cycle after the handshake cycle.
REQ-026 SHALL drive w_regs_en = 0 for a granted transfer with addr 0 (x0 writes are consumed but dropped); w_regs_addr/data SHALL still update.
REQ-027 SHALL drive w_regs_en = 0 in any cycle following a cycle with no transfer; addr/data SHALL hold their last values.
REQ-028 SHALL keep a 32-bit pending scoreboard; bit 0 SHALL always read 0.
REQ-029 SHALL set scoreboard[sb_set_addr] on sb_set_en when sb_set_addr != 0.
REQ-030 SHALL clear scoreboard[p1_addr] when p1 transfers.
REQ-031 SHALL resolve set and clear of the same register in one cycle as set (new op supersedes).
REQ-032 SHALL not touch the scoreboard on p0 transfers.
REQ-033 SHALL drive q_busy1 = scoreboard[q_addr1] and q_busy2 = scoreboard[q_addr2] combinationally from the registered scoreboard (update visible the cycle after set/clear).
REQ-034 SHALL ignore data/addr inputs while the corresponding valid is low.

Reset
REQ-035 SHALL, on a rising clk edge with rst low, clear w_regs_en, w_regs_addr, w_regs_data, wait_cnt and all scoreboard bits to 0, discarding any in-flight transfer.
REQ-036 SHALL hold p0_ready and p1_ready at 0 while rst is low.
REQ-037 SHALL accept requests normally from the first edge where rst is high.

Verification
REQ-038 Lone p0: p0_valid=1, addr=5, data=0xDEADBEEF at cycle N -> p0_ready=1 at N; w_regs_en=1, addr=5, data=0xDEADBEEF at N+1; w_regs_en=0 at N+2.
REQ-039 Contention: p0 and p1 both valid continuously, MAX_WAIT=4 -> p0 granted cycles N..N+3, p1 granted at N+4, then p0 again at N+5.
REQ-040 Scoreboard: sb_set_en, addr=7 at N; q_addr1=7 -> q_busy1=1 from N+1; p1 transfers addr=7 at M -> q_busy1=0 from M+1.
REQ-041 Set/clear collision: sb_set_en addr=9 and p1 transfer addr=9 in same cycle -> scoreboard[9]=1 afterwards.
REQ-042 x0: p1 transfer addr=0, data=0x1234 -> p1_ready=1, w_regs_en=0 next cycle; sb_set_en addr=0 -> q_busy for addr 0 stays 0.
REQ-043 Reset mid-operation: scoreboard bits 3 and 12 set, transfer granted, rst=0 at next edge -> w_regs_en=0, all q_busy=0, wait_cnt=0.
